// File: rtl/vga_pkg.sv
// Shared framebuffer types: default address/pixel widths and the arbiter
// mem-stage ownership encoding.
package vga_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 6;

    typedef logic [FB_DATA_W-1:0] pixel_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DISP = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_starve_timer.sv
// Saturating writer wait counter; sat is high once LIMIT waiting cycles
// have accumulated and stays high until clr.
module fb_starve_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == LIMIT_C);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer SRAM arbiter between display scan-out and a writer.
// Optional writer starvation guard enabled by defining FB_ARB_STARVE_GUARD_EN.
module fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_miss,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        arb_state
);

    // Handshake: a request is taken in any cycle where req/valid and gnt/ready
    // are both high; the requester holds address/data stable until then, and
    // the arbiter samples them only in that cycle.

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    end

    arb_state_t        arb_next;
    logic              force_wr;
    logic [DATA_W-1:0] rdata_q;

`ifdef FB_ARB_STARVE_GUARD_EN
    logic starve_sat;

    fb_starve_timer #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_timer (
        .clk (clk),
        .rst (rst),
        .inc (wr_valid && !wr_ready),
        .clr (wr_ready || !wr_valid),
        .sat (starve_sat)
    );

    assign force_wr  = starve_sat && wr_valid;
    assign disp_miss = !rst && disp_req && force_wr;
`else
    assign force_wr  = 1'b0;
    assign disp_miss = 1'b0;
`endif

    // Grants are gated by rst so nothing is accepted while reset is held.
    assign disp_gnt = !rst && disp_req && !force_wr;
    assign wr_ready = !rst && wr_valid && (force_wr || !disp_req);

    always_comb begin
        arb_next = ARB_IDLE;
        if (disp_gnt) begin
            arb_next = ARB_DISP;
        end else if (wr_ready) begin
            arb_next = ARB_WR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state <= ARB_IDLE;
        end else begin
            arb_state <= arb_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= disp_gnt || wr_ready;
            mem_we <= wr_ready;
            if (wr_ready) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (disp_gnt) begin
                mem_addr <= disp_addr;
            end
        end
    end

    // A read owning the mem stage returns SRAM data on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_rvalid <= 1'b0;
            rdata_q     <= '0;
        end else begin
            disp_rvalid <= (arb_state == ARB_DISP);
            if (disp_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign disp_rdata = disp_rvalid ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: vector table plus contention and
// reset-during-read sequences, with a small SRAM model on the mem port.
module tb_fb_arbiter;
    import vga_pkg::*;

    localparam int AW = 19;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          disp_miss;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    arb_state_t    arb_state;

    int checks = 0;
    int errors = 0;

    fb_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .disp_miss(disp_miss),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous single port, read data one cycle after mem_en.
    logic [DW-1:0] sram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr[11:0]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[11:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst, dr;
        logic [AW-1:0] da;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          gnt, wrdy, miss, men, mwe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        logic          rv;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs [0:11];

    task automatic drive(input logic r, input logic dr, input logic [AW-1:0] da,
                         input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clk);
        rst = r; disp_req = dr; disp_addr = da;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = '0;
        sram[12'h123] = 6'b111001;
        sram[12'h010] = 6'h15;

        //          rst   dr    da          wv    wa          wd     gnt   wrdy  miss  men   mwe   maddr       mwd    rv    rd
        vecs[0]  = '{1'b1,1'b1,19'h00000,1'b1,19'h00000,6'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,19'h00000,6'h00, 1'b0,6'h00};
        vecs[1]  = '{1'b0,1'b1,19'h00123,1'b0,19'h00000,6'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,19'h00000,6'h00, 1'b0,6'h00};
        vecs[2]  = '{1'b0,1'b0,19'h00000,1'b1,19'h4AFFF,6'h2A, 1'b0,1'b1,1'b0,1'b1,1'b0,19'h00123,6'h00, 1'b0,6'h00};
        vecs[3]  = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,6'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,19'h4AFFF,6'h2A, 1'b1,6'h39};
        vecs[4]  = '{1'b0,1'b1,19'h4AFFF,1'b1,19'h00010,6'h07, 1'b1,1'b0,1'b0,1'b0,1'b0,19'h4AFFF,6'h2A, 1'b0,6'h39};
        vecs[5]  = '{1'b0,1'b1,19'h00010,1'b1,19'h00010,6'h07, 1'b1,1'b0,1'b0,1'b1,1'b0,19'h4AFFF,6'h2A, 1'b0,6'h39};
        vecs[6]  = '{1'b0,1'b0,19'h00000,1'b1,19'h00010,6'h07, 1'b0,1'b1,1'b0,1'b1,1'b0,19'h00010,6'h2A, 1'b1,6'h2A};
        vecs[7]  = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,6'h00, 1'b0,1'b0,1'b0,1'b1,1'b1,19'h00010,6'h07, 1'b1,6'h15};
        vecs[8]  = '{1'b0,1'b1,19'h00010,1'b0,19'h00000,6'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,19'h00010,6'h07, 1'b0,6'h15};
        vecs[9]  = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,6'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,19'h00010,6'h07, 1'b0,6'h15};
        vecs[10] = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,6'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,19'h00010,6'h07, 1'b1,6'h07};
        vecs[11] = '{1'b0,1'b0,19'h00000,1'b0,19'h00000,6'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,19'h00010,6'h07, 1'b0,6'h07};

        repeat (3) @(posedge clk);

        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].rst, vecs[v].dr, vecs[v].da, vecs[v].wv, vecs[v].wa, vecs[v].wd);
            check($sformatf("v%0d_disp_gnt", v),    32'(disp_gnt),    32'(vecs[v].gnt));
            check($sformatf("v%0d_wr_ready", v),    32'(wr_ready),    32'(vecs[v].wrdy));
            check($sformatf("v%0d_disp_miss", v),   32'(disp_miss),   32'(vecs[v].miss));
            check($sformatf("v%0d_mem_en", v),      32'(mem_en),      32'(vecs[v].men));
            check($sformatf("v%0d_mem_we", v),      32'(mem_we),      32'(vecs[v].mwe));
            check($sformatf("v%0d_mem_addr", v),    32'(mem_addr),    32'(vecs[v].maddr));
            check($sformatf("v%0d_mem_wdata", v),   32'(mem_wdata),   32'(vecs[v].mwd));
            check($sformatf("v%0d_disp_rvalid", v), 32'(disp_rvalid), 32'(vecs[v].rv));
            check($sformatf("v%0d_disp_rdata", v),  32'(disp_rdata),  32'(vecs[v].rd));
        end

        // Continuous contention from an idle (counter-clear) start.
`ifdef FB_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 68; i++) begin
            logic exp_wr;
            exp_wr = ((i % 17) == 16);
            drive(1'b0, 1'b1, 19'h00123, 1'b1, 19'h00200, 6'h11);
            check($sformatf("cont%0d_wr_ready", i),  32'(wr_ready),  32'(exp_wr));
            check($sformatf("cont%0d_disp_gnt", i),  32'(disp_gnt),  32'(!exp_wr));
            check($sformatf("cont%0d_disp_miss", i), 32'(disp_miss), 32'(exp_wr));
        end
`else
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 19'h00123, 1'b1, 19'h00200, 6'h11);
            check($sformatf("cont%0d_wr_ready", i),  32'(wr_ready),  32'h0);
            check($sformatf("cont%0d_disp_gnt", i),  32'(disp_gnt),  32'h1);
            check($sformatf("cont%0d_disp_miss", i), 32'(disp_miss), 32'h0);
        end
`endif
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
        repeat (3) drive(1'b0, 1'b0, '0, 1'b0, '0, '0);

        // Reset pulse right after a read grant discards the read.
        drive(1'b0, 1'b1, 19'h00123, 1'b0, '0, '0);
        check("rmr_grant", 32'(disp_gnt), 32'h1);
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
        check("rmr_rvalid_c6", 32'(disp_rvalid), 32'h0);
        check("rmr_mem_en_c6", 32'(mem_en), 32'h0);
        check("rmr_state_c6", 32'(arb_state), 32'(ARB_IDLE));
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
        check("rmr_rvalid_c7", 32'(disp_rvalid), 32'h0);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
        check("rmr_rvalid_c8", 32'(disp_rvalid), 32'h0);
        check("rmr_rdata_c8", 32'(disp_rdata), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, framebuffer word address width (640x480 pixels).
REQ-002 Parameter DATA_W, default 6, pixel width (2-bit R, G, B).
REQ-003 Parameter STARVE_LIMIT, default 16, writer wait cycles before forced writer slot.
REQ-004 clk  in  1  pixel clock; sole clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 disp_req  in  1  display scan-out read request.
REQ-007 disp_addr  in  ADDR_W  display read address.
REQ-008 disp_gnt  out  1  display request accepted this cycle.
REQ-009 disp_rvalid  out  1  disp_rdata valid.
REQ-010 disp_rdata  out  DATA_W  pixel read for display.
REQ-011 disp_miss  out  1  one-cycle pulse: display request denied.
REQ-012 wr_valid  in  1  writer has pending write.
REQ-013 wr_addr  in  ADDR_W  write address.
REQ-014 wr_data  in  DATA_W  write pixel.
REQ-015 wr_ready  out  1  write accepted this cycle.
REQ-016 mem_en, mem_we  out  1 each  single-port SRAM enable, write enable.
REQ-017 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  SRAM port; read data one cycle after mem_en.

Function
REQ-018 At most one of disp_gnt, wr_ready SHALL be high per cycle; both are combinational from current requests and registered state.
REQ-019 Default priority: disp_req wins over wr_valid.
REQ-020 Writer forced slot: when wait counter equals STARVE_LIMIT and wr_valid=1, wr_ready=1 and disp_gnt=0 regardless of disp_req; disp_miss=1 that cycle if disp_req=1.
REQ-021 Wait counter increments each cycle wr_valid=1 and wr_ready=0, saturates at STARVE_LIMIT, clears on wr_ready=1 or wr_valid=0.
REQ-022 Accepted request in cycle N SHALL drive registered mem_en/mem_we/mem_addr/mem_wdata in cycle N+1; mem_en=0 in cycles with no grant.
REQ-023 Display read accepted in cycle N: disp_rvalid=1, disp_rdata=mem_rdata in cycle N+2; rvalid pulses once per grant; back-to-back grants give back-to-back rvalid.
REQ-024 State register arb_state in {ARB_IDLE, ARB_DISP, ARB_WR} records owner of the mem stage: next state ARB_DISP on disp_gnt, ARB_WR on wr_ready, else ARB_IDLE.
REQ-025 Writer inputs SHALL be held stable while wr_valid=1 and wr_ready=0; arbiter samples them only in the wr_ready cycle.
REQ-026 Display and writer targeting the same address in consecutive cycles: memory order equals grant order; no forwarding.
REQ-027 disp_rdata SHALL hold its last value when disp_rvalid=0.

Reset
REQ-028 During rst: disp_gnt, wr_ready, disp_rvalid, disp_miss, mem_en, mem_we = 0; mem_addr, mem_wdata, disp_rdata = 0; arb_state=ARB_IDLE; wait counter=0.
REQ-029 Reset asserted mid-operation discards in-flight reads; no disp_rvalid SHALL follow reset deassertion for pre-reset grants.
REQ-030 First grant possible in the first clk edge after rst deasserts.

Configuration
REQ-031 Macro FB_ARB_STARVE_GUARD_EN defined: REQ-020/021 active.
REQ-032 Macro undefined: no wait counter, strict display priority, disp_miss tied 0, STARVE_LIMIT ignored.

Structure
REQ-033 Package vga_pkg SHALL hold ADDR_W/DATA_W defaults, pixel_t (DATA_W bits), fb_addr_t, and arb_state_t enum.
REQ-034 Wait counter SHALL be sub-module fb_starve_timer (inc, clr, sat output), instantiated only under FB_ARB_STARVE_GUARD_EN.

Verification
REQ-035 Reset: rst=1 with disp_req=1, wr_valid=1 -> all outputs 0; rst low -> disp_gnt=1 next cycle.
REQ-036 Display read: disp_req=1 at addr 0x00123 in cycle 10, mem_rdata=6'b111001 in cycle 12 -> mem_en=1/mem_we=0/addr 0x00123 cycle 11, disp_rvalid=1 with 6'b111001 cycle 12.
REQ-037 Write only: wr_valid=1 addr 0x4AFFF data 6'h2A -> wr_ready=1 same cycle, mem_we=1 addr 0x4AFFF data 6'h2A next cycle.
REQ-038 Contention (guard on): disp_req and wr_valid high continuously -> 16 disp_gnt cycles, then wr_ready=1 with disp_miss=1 on cycle 17, pattern repeats.
REQ-039 Contention (guard off): same stimulus for 100 cycles -> wr_ready never 1, disp_miss never 1.
REQ-040 Reset mid-read: grant in cycle 5, rst pulse in cycle 6 -> no disp_rvalid in cycles 6-8.
